// File: rtl/m_store_buffer_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// m_store_buffer_pkg
// Store opcodes and the lane-aligned payload shared by the store buffer
// and its alignment helper.
// Revision: 1.0
// ---------------------------------------------------------------------------
package m_store_buffer_pkg;

  // Store opcode from the M stage
  typedef enum logic [2:0] {
    ST_NONE = 3'd0,
    ST_SW   = 3'd1,
    ST_SH   = 3'd2,
    ST_SB   = 3'd3
  } st_op_e;

  // Word-lane aligned store payload
  typedef struct packed {
    logic [3:0]  be;
    logic [31:0] wdata;
  } lane_t;

endpackage : m_store_buffer_pkg
`default_nettype wire

// File: rtl/m_store_buffer_align.sv
`default_nettype none
// ---------------------------------------------------------------------------
// m_st_align
// Combinational store aligner: replicates store data onto the word lanes,
// builds byte enables and flags misaligned halfword/word stores.
// Revision: 1.0
// ---------------------------------------------------------------------------
module m_st_align
  import m_store_buffer_pkg::*;
(
  input  logic [2:0]  op_i,
  input  logic [1:0]  addr_i,
  input  logic [31:0] data_i,
  output logic        req_o,
  output lane_t       lane_o,
  output logic        misaligned_o
);

  // Decode opcode into lane payload and alignment status
  always_comb begin
    req_o        = 1'b0;
    lane_o       = '0;
    misaligned_o = 1'b0;
    case (st_op_e'(op_i))
      ST_SW: begin
        req_o        = 1'b1;
        lane_o.be    = 4'b1111;
        lane_o.wdata = data_i;
        misaligned_o = (addr_i != 2'b00);
      end
      ST_SH: begin
        req_o        = 1'b1;
        lane_o.be    = 4'b0011 << addr_i;
        lane_o.wdata = {2{data_i[15:0]}};
        misaligned_o = addr_i[0];
      end
      ST_SB: begin
        req_o        = 1'b1;
        lane_o.be    = 4'b0001 << addr_i;
        lane_o.wdata = {4{data_i[7:0]}};
      end
      default: ;
    endcase
  end

endmodule : m_st_align
`default_nettype wire

// File: rtl/m_store_buffer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// m_store_buffer
// M-stage store buffer: aligns sw/sh/sb, queues them in a DEPTH-entry FIFO
// and drains them in order over a req/ack bus. Stalls the pipeline when the
// queue cannot accept a store or a load word-overlaps a pending store.
// Revision: 1.0
// ---------------------------------------------------------------------------
module m_store_buffer
  import m_store_buffer_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int AW    = 32
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          st_valid,
  input  logic [2:0]    st_op,
  input  logic [AW-1:0] st_addr,
  input  logic [31:0]   st_data,
  input  logic          ld_valid,
  input  logic [AW-1:0] ld_addr,
  output logic          stall,
  output logic          exc_ades,
  output logic          bus_req,
  output logic [AW-1:0] bus_addr,
  output logic [31:0]   bus_wdata,
  output logic [3:0]    bus_be,
  input  logic          bus_ack,
  output logic          empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [AW-3:0]    waddr_q [DEPTH];
  lane_t            lane_q  [DEPTH];
  logic [DEPTH-1:0] valid_q;
  logic [PW-1:0]    rd_q, wr_q;
  logic [CW-1:0]    count_q, count_d;

  logic  al_req, al_mis, legal, full, full_eff, hit, push, pop;
  lane_t al_lane;

  m_st_align u_align (
    .op_i         (st_op),
    .addr_i       (st_addr[1:0]),
    .data_i       (st_data),
    .req_o        (al_req),
    .lane_o       (al_lane),
    .misaligned_o (al_mis)
  );

  // Byte offset of a load never matters: overlap is judged per word
  logic unused_ld_lo;
  assign unused_ld_lo = &{1'b0, ld_addr[1:0]};

  assign legal    = al_req & ~al_mis;
  assign exc_ades = st_valid & al_req & al_mis;
  assign full     = (count_q == CW'(DEPTH));
  assign empty    = (count_q == '0);
  assign bus_req  = ~empty;
  assign pop      = bus_req & bus_ack;
  // A full queue draining this cycle frees the slot the push will use
  assign full_eff = full & ~pop;

  // Conservative word-granular overlap check against every pending store
  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && (waddr_q[i] == ld_addr[AW-1:2])) hit = 1'b1;
    end
  end

  assign stall = (st_valid & legal & full_eff) | (ld_valid & hit);
  assign push  = st_valid & legal & ~stall;

  assign bus_addr  = bus_req ? {waddr_q[rd_q], 2'b00} : '0;
  assign bus_wdata = bus_req ? lane_q[rd_q].wdata : '0;
  assign bus_be    = bus_req ? lane_q[rd_q].be : '0;

  // Occupancy update from push/pop
  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: ;
    endcase
  end

  // Queue storage, pointers and occupancy; pop is applied before push so a
  // full-queue push into the slot being freed leaves it valid
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        waddr_q[i] <= '0;
        lane_q[i]  <= '0;
      end
      valid_q <= '0;
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
    end else begin
      if (pop) begin
        valid_q[rd_q] <= 1'b0;
        rd_q          <= rd_q + 1'b1;
      end
      if (push) begin
        waddr_q[wr_q] <= st_addr[AW-1:2];
        lane_q[wr_q]  <= al_lane;
        valid_q[wr_q] <= 1'b1;
        wr_q          <= wr_q + 1'b1;
      end
      count_q <= count_d;
    end
  end

endmodule : m_store_buffer
`default_nettype wire

// File: tb/tb_m_store_buffer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_m_store_buffer
// Self-checking bench for m_store_buffer against a queue-based model.
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_m_store_buffer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        st_valid, ld_valid, bus_ack;
  logic [2:0]  st_op;
  logic [31:0] st_addr, st_data, ld_addr;
  logic        stall, exc_ades, bus_req, empty;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_be;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  be;
  } ent_t;

  ent_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  m_store_buffer #(.DEPTH(2), .AW(32)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .st_valid  (st_valid),
    .st_op     (st_op),
    .st_addr   (st_addr),
    .st_data   (st_data),
    .ld_valid  (ld_valid),
    .ld_addr   (ld_addr),
    .stall     (stall),
    .exc_ades  (exc_ades),
    .bus_req   (bus_req),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_be    (bus_be),
    .bus_ack   (bus_ack),
    .empty     (empty)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One bus cycle: drive inputs, check against the model, clock, update model
  task automatic cyc(input logic sv, input logic [2:0] op, input logic [31:0] a,
                     input logic [31:0] d, input logic lv, input logic [31:0] la,
                     input logic ack);
    logic       is_st, aligned, legal, e_ades, hit, e_stall, e_pop, e_push;
    logic [3:0] be;
    logic [31:0] wd;
    int          off;
    st_valid = sv; st_op = op; st_addr = a; st_data = d;
    ld_valid = lv; ld_addr = la; bus_ack = ack;
    #2;
    off     = int'(a[1:0]);
    is_st   = (op == 3'd1) || (op == 3'd2) || (op == 3'd3);
    aligned = (op == 3'd1) ? (off == 0) : (op == 3'd2) ? (off % 2 == 0) : 1'b1;
    be      = (op == 3'd1) ? 4'hF : (op == 3'd2) ? 4'(3 << off) : 4'(1 << off);
    wd      = (op == 3'd1) ? d : (op == 3'd2) ? d[15:0] * 32'h0001_0001
                                              : d[7:0] * 32'h0101_0101;
    legal   = is_st && aligned;
    e_ades  = sv && is_st && !aligned;
    hit     = 1'b0;
    foreach (q[i]) if (q[i].a[31:2] == la[31:2]) hit = 1'b1;
    e_pop   = (q.size() > 0) && ack;
    e_stall = (sv && legal && q.size() == 2 && !e_pop) || (lv && hit);
    e_push  = sv && legal && !e_stall;
    check("stall", 32'(stall), 32'(e_stall));
    check("ades", 32'(exc_ades), 32'(e_ades));
    check("req", 32'(bus_req), 32'(q.size() > 0));
    check("empty", 32'(empty), 32'(q.size() == 0));
    if (q.size() > 0) begin
      check("addr", bus_addr, {q[0].a[31:2], 2'b00});
      check("wdata", bus_wdata, q[0].d);
      check("be", 32'(bus_be), 32'(q[0].be));
    end
    @(posedge clk);
    #1;
    if (e_pop) void'(q.pop_front());
    if (e_push) q.push_back('{a: a, d: wd, be: be});
  endtask

  task automatic idle(input logic ack);
    cyc(1'b0, 3'd0, 32'h0, 32'h0, 1'b0, 32'h0, ack);
  endtask

  initial begin
    reset_n = 1'b0;
    st_valid = 1'b0; st_op = 3'd0; st_addr = '0; st_data = '0;
    ld_valid = 1'b0; ld_addr = '0; bus_ack = 1'b0;
    #12;
    check("rst_req", 32'(bus_req), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_addr", bus_addr, 32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;

    // 1: byte store, ack held high
    cyc(1'b1, 3'd3, 32'h1003, 32'hAB, 1'b0, 32'h0, 1'b1);
    check("t1_req", 32'(bus_req), 32'd1);
    check("t1_addr", bus_addr, 32'h1000);
    check("t1_be", 32'(bus_be), 32'h8);
    check("t1_wdata", bus_wdata, 32'hABAB_ABAB);
    idle(1'b1);

    // 2: misaligned then aligned halfword
    cyc(1'b1, 3'd2, 32'h2001, 32'h1234, 1'b0, 32'h0, 1'b0);
    check("t2_noreq", 32'(bus_req), 32'd0);
    cyc(1'b1, 3'd2, 32'h2002, 32'h1234, 1'b0, 32'h0, 1'b0);
    check("t2_be", 32'(bus_be), 32'hC);
    check("t2_wdata", bus_wdata, 32'h1234_1234);
    idle(1'b1);

    // 3: three back-to-back words with ack low, then one ack
    cyc(1'b1, 3'd1, 32'h5000, 32'h1111_1111, 1'b0, 32'h0, 1'b0);
    cyc(1'b1, 3'd1, 32'h5004, 32'h2222_2222, 1'b0, 32'h0, 1'b0);
    cyc(1'b1, 3'd1, 32'h5008, 32'h3333_3333, 1'b0, 32'h0, 1'b0);
    cyc(1'b1, 3'd1, 32'h5008, 32'h3333_3333, 1'b0, 32'h0, 1'b1);
    check("t3_second", bus_wdata, 32'h2222_2222);
    idle(1'b1);
    check("t3_third", bus_wdata, 32'h3333_3333);
    idle(1'b1);

    // 4: load overlap with a pending store
    cyc(1'b1, 3'd1, 32'h3000, 32'hCAFE_F00D, 1'b0, 32'h0, 1'b0);
    cyc(1'b0, 3'd0, 32'h0, 32'h0, 1'b1, 32'h3002, 1'b0);
    cyc(1'b0, 3'd0, 32'h0, 32'h0, 1'b1, 32'h3002, 1'b1);
    cyc(1'b0, 3'd0, 32'h0, 32'h0, 1'b1, 32'h3002, 1'b0);
    cyc(1'b0, 3'd0, 32'h0, 32'h0, 1'b1, 32'h3004, 1'b0);

    // 5: asynchronous reset with two entries queued
    cyc(1'b1, 3'd1, 32'h6000, 32'hA5A5_0001, 1'b0, 32'h0, 1'b0);
    cyc(1'b1, 3'd1, 32'h6004, 32'hA5A5_0002, 1'b0, 32'h0, 1'b0);
    st_valid = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    check("t5_req", 32'(bus_req), 32'd0);
    check("t5_empty", 32'(empty), 32'd1);
    q.delete();
    @(posedge clk); #1;
    reset_n = 1'b1;
    cyc(1'b1, 3'd1, 32'h7000, 32'h7777_0000, 1'b0, 32'h0, 1'b0);
    check("t5_after", 32'(bus_req), 32'd1);
    check("t5_addr", bus_addr, 32'h7000);
    idle(1'b1);

    // 6: ack while empty
    idle(1'b1);
    idle(1'b1);

    // Random mix over a small address window so overlaps are frequent
    for (int n = 0; n < 2000; n++) begin
      cyc(1'($urandom_range(0, 1)), 3'($urandom_range(0, 4)),
          32'h8000 + 32'($urandom_range(0, 15)), $urandom,
          1'($urandom_range(0, 1)), 32'h8000 + 32'($urandom_range(0, 15)),
          1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_m_store_buffer
`default_nettype wire
